// File: rtl/carry_resolve_if.sv
// rtl/carry_resolve_if.sv - operand and result handshake bundle for carry_resolve
interface carry_resolve_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] g;
  logic [31:0] p;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic [32:0] carries;
  logic        cout;
  logic        overflow;

  modport master (
    output in_valid, g, p, cin, out_ready,
    input  in_ready, out_valid, sum, carries, cout, overflow
  );

  modport slave (
    input  in_valid, g, p, cin, out_ready,
    output in_ready, out_valid, sum, carries, cout, overflow
  );
endinterface

// File: rtl/carry_resolve.sv
// rtl/carry_resolve.sv - multi-cycle carry resolution, one 8-bit block per clock
module carry_resolve (
  input logic            clock,
  input logic            reset,
  carry_resolve_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  blk;
  logic [31:0] g_r;
  logic [31:0] p_r;
  logic [32:0] c_r;
  logic [32:0] c_nxt;
  logic [5:0]  pos;
  logic [31:0] sum_r;
  logic [32:0] carries_r;
  logic        cout_r;
  logic        ovf_r;

  // Ripple through block blk, starting from the carry left by the previous block.
  always_comb begin
    c_nxt = c_r;
    pos   = '0;
    for (int j = 0; j < 8; j++) begin
      pos = {1'b0, blk, 3'(j)};
      c_nxt[pos + 6'd1] = g_r[pos[4:0]] | (p_r[pos[4:0]] & c_nxt[pos]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (blk == 2'd3)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blk       <= 2'd0;
      g_r       <= '0;
      p_r       <= '0;
      c_r       <= '0;
      sum_r     <= '0;
      carries_r <= '0;
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            g_r <= bus.g;
            p_r <= bus.p;
            c_r <= {32'd0, bus.cin};
            blk <= 2'd0;
          end
        end
        BUSY: begin
          c_r <= c_nxt;
          blk <= blk + 2'd1;
          if (blk == 2'd3) begin
            sum_r     <= p_r ^ c_nxt[31:0];
            carries_r <= c_nxt;
            cout_r    <= c_nxt[32];
            ovf_r     <= c_nxt[32] ^ c_nxt[31];
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode the state register only, so no input reaches an output.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.carries   = carries_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;
endmodule

// File: doc/carry_resolve.md
CARRY_RESOLVE -- requirements
Module: carry_resolve

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL change only on the rising edge of clock or on assertion of reset.
REQ-002 Port: clock  in  1  system clock; all sampling on the rising edge.
REQ-003 Port: reset  in  1  asynchronous reset, active-low (0 = reset).
REQ-004 Port: in_valid  in  1  the operand bundle on g/p/cin is valid.
REQ-005 Port: in_ready  out  1  the block accepts a bundle this cycle.
REQ-006 Port: g  in  32  per-bit generate, g[i] = A[i] & B[i], as produced by the team's gen unit.
REQ-007 Port: p  in  32  per-bit propagate, p[i] = A[i] ^ B[i].
REQ-008 Port: cin  in  1  carry into bit 0.
REQ-009 Port: out_valid  out  1  result fields are valid.
REQ-010 Port: out_ready  in  1  the downstream consumer takes the result this cycle.
REQ-011 Port: sum  out  32  sum[i] = p[i] ^ c[i].
REQ-012 Port: carries  out  33  c[0..32], with c[0] = cin and c[32] = carry out.
REQ-013 Port: cout  out  1  equals c[32].
REQ-014 Port: overflow  out  1  signed overflow, c[32] ^ c[31].

Function
REQ-015 State machine states: IDLE, BUSY, DONE; there is a 2-bit block counter blk.
REQ-016 in_ready SHALL be 1 only in IDLE; it is a registered-state decode and is never combinational from out_ready.
REQ-017 Accept: in IDLE with in_valid=1 at an edge, the block latches g, p and cin into internal registers, sets c[0]=cin, sets blk=0, and moves to BUSY.
REQ-018 In IDLE with in_valid=0, the block stays in IDLE with all registers held.
REQ-019 BUSY, at each edge: resolve the 8-bit block k=blk with a ripple-lookahead: for j=0..7, c[8k+j+1] = g[8k+j] | (p[8k+j] & c[8k+j]), using c[8k] from the previous block; then blk increments.
REQ-020 BUSY, edge with blk=3: resolve block 3, write the sum, cout and overflow registers, set out_valid=1, move to DONE; blk wraps to 0.
REQ-021 Latency: out_valid SHALL rise exactly 4 clock edges after the accept edge; the design SHALL have no early-exit path.
REQ-022 In BUSY, in_valid, g, p and cin are ignored; the latched copy alone determines the result.
REQ-023 DONE: sum, carries, cout, overflow and out_valid SHALL be held stable until out_ready=1 at an edge.
REQ-024 DONE with out_ready=1 at an edge: clear out_valid and move to IDLE; the result fields keep their last values.
REQ-025 Back-to-back operation: at most one bundle every 6 cycles (accept, 4 BUSY edges, DONE handshake); in_ready returns to 1 in the cycle after the output handshake.
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 All outputs are registered; the block SHALL have no combinational path from any input to any output.

Reset
REQ-028 On reset=0, regardless of clock, the block SHALL enter IDLE with blk=0, out_valid=0, in_ready=1 (once in IDLE), and sum, carries, cout and overflow all 0.
REQ-029 Reset asserted while in BUSY or DONE SHALL abort the operation with no result presented; after reset deasserts, the next accept starts a clean operation.
REQ-030 The first accept after reset deasserts is allowed at the first rising edge that sees reset=1.

Verification
REQ-031 A=0xFFFFFFFF, B=0x00000001, cin=0 (g=0x00000001, p=0xFFFFFFFE) -> sum=0x00000000, cout=1, overflow=0, carries=0x1FFFFFFFE, out_valid exactly 4 edges after accept.
REQ-032 A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
REQ-033 A=0x00000005, B=0x00000003, cin=1 -> sum=0x00000009, cout=0, overflow=0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid, g and p -> outputs stay stable, in_ready=0; then pulse out_ready -> out_valid=0 and in_ready=1 on the next cycle.
REQ-035 Assert reset in the second BUSY cycle -> out_valid never rises and all outputs read 0; the next operation, A=2, B=2, gives sum=0x00000004.
REQ-036 Apply 1000 random A/B/cin values with random out_ready stalls -> sum and cout match A+B+cin in every case, and the bench checks latency=4 on each operation.
